// File: rtl/reg_bank4x16.sv
// Four-entry 16-bit register bank with one-hot write decode, mux4way16 read path,
// registered read output and per-entry dirty tracking.
// Optional same-cycle read forwarding is enabled by defining REG_BANK_BYPASS_EN.

module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    unique case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

module reg_bank4x16 #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [1:0]  address,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  output logic [15:0] out,
  output logic        out_valid,
  output logic [3:0]  dirty
);

  logic [15:0] entry [4];
  logic [3:0]  wr_onehot;
  logic [3:0]  dirty_nxt;
  logic [15:0] mux_out;
  logic [15:0] rd_data;

  // Clear suppresses the write strobe, so storage and dirty both see clear > load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_onehot = '0;
    if (load && !clear) wr_onehot[address] = 1'b1;
  end

  mux4way16 u_mux (
    .a   (entry[0]),
    .b   (entry[1]),
    .c   (entry[2]),
    .d   (entry[3]),
    .sel (rd_sel),
    .out (mux_out)
  );

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    rd_data = mux_out;
    if (clear)                  rd_data = RESET_VAL;
    else if (wr_onehot[rd_sel]) rd_data = in;
  end
`else
  assign rd_data = mux_out;
`endif

  // A read retires the dirty bit, but a same-cycle write to that entry re-marks it.
  always_comb begin
    dirty_nxt = dirty;
    if (rd_en) dirty_nxt[rd_sel] = 1'b0;
    dirty_nxt = dirty_nxt | wr_onehot;
    if (clear) dirty_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this bank is discrete flops, not a RAM macro, so resetting every entry is legal and intended.
      for (int i = 0; i < 4; i++) entry[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (clear)             entry[i] <= RESET_VAL;
        else if (wr_onehot[i]) entry[i] <= in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 16'h0000;
      out_valid <= 1'b0;
      dirty     <= 4'b0000;
    end else begin
      out_valid <= rd_en;
      dirty     <= dirty_nxt;
      if (rd_en) out <= rd_data;
    end
  end

endmodule

// File: tb/tb_reg_bank4x16.sv
// Scoreboard bench for reg_bank4x16: stimulus pushes expected read data and due cycle,
// a negedge monitor pops and compares whenever out_valid is presented.

module tb_reg_bank4x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [1:0]  address;
  logic        clear;
  logic        rd_en;
  logic [1:0]  rd_sel;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  dirty;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  reg_bank4x16 #(.RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .address   (address),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .out       (out),
    .out_valid (out_valid),
    .dirty     (dirty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per presented read result, checked for data and latency.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out=%0h with no pending read (t=%0t)", out, $time);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", {16'h0, out}, {16'h0, mon_e.data});
        check("rd_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [15:0] d);
    load    = 1'b1;
    address = a;
    in      = d;
    tick();
    load = 1'b0;
  endtask

  task automatic read_req(input logic [1:0] s, input logic [15:0] exp_data);
    rd_en  = 1'b1;
    rd_sel = s;
    sb.push_back('{data: exp_data, due: cyc + 1});
    tick();
    rd_en = 1'b0;
  endtask

  logic [15:0] exp_val;

  initial begin
    rst_n = 1'b0; in = 16'h0; load = 1'b0; address = 2'd0;
    clear = 1'b0; rd_en = 1'b0; rd_sel = 2'd0;

    // 1. Reset held while a write is attempted.
    load = 1'b1; in = 16'hFFFF; address = 2'd0;
    repeat (3) tick();
    check("rst_out", {16'h0, out}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_dirty", {28'h0, dirty}, 32'h0);
    load = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) read_req(i[1:0], 16'h0000);
    check("rst_dirty_after_reads", {28'h0, dirty}, 32'h0);

    // 2. Write all entries, read them back to back.
    write(2'd0, 16'h1111);
    write(2'd1, 16'h2222);
    write(2'd2, 16'h3333);
    write(2'd3, 16'h4444);
    check("dirty_all_written", {28'h0, dirty}, 32'hF);
    read_req(2'd0, 16'h1111);
    read_req(2'd1, 16'h2222);
    read_req(2'd2, 16'h3333);
    read_req(2'd3, 16'h4444);
    check("dirty_after_reads", {28'h0, dirty}, 32'h0);

    // 6. Idle hold after the 16'h4444 read.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_out", {16'h0, out}, 32'h4444);
      check("idle_valid", {31'h0, out_valid}, 32'h0);
    end

    // 3. Read-during-write on the same entry.
    write(2'd2, 16'h3333);
    check("dirty_e2", {28'h0, dirty}, 32'h4);
`ifdef REG_BANK_BYPASS_EN
    exp_val = 16'hBEEF;
`else
    exp_val = 16'h3333;
`endif
    load = 1'b1; address = 2'd2; in = 16'hBEEF;
    rd_en = 1'b1; rd_sel = 2'd2;
    sb.push_back('{data: exp_val, due: cyc + 1});
    tick();
    load = 1'b0; rd_en = 1'b0;
    check("rdw_dirty_write_wins", {28'h0, dirty}, 32'h4);
    read_req(2'd2, 16'hBEEF);
    check("rdw_dirty_cleared", {28'h0, dirty}, 32'h0);

    // 4. Clear beats load; concurrent read sees pre-clear data (or RESET_VAL with bypass).
    write(2'd0, 16'h1234);
    write(2'd1, 16'h5678);
    write(2'd2, 16'h9ABC);
    write(2'd3, 16'hDEF0);
`ifdef REG_BANK_BYPASS_EN
    exp_val = 16'h0000;
`else
    exp_val = 16'h5678;
`endif
    clear = 1'b1; load = 1'b1; address = 2'd1; in = 16'hA5A5;
    rd_en = 1'b1; rd_sel = 2'd1;
    sb.push_back('{data: exp_val, due: cyc + 1});
    tick();
    clear = 1'b0; load = 1'b0; rd_en = 1'b0;
    check("clear_dirty", {28'h0, dirty}, 32'h0);
    for (int i = 0; i < 4; i++) read_req(i[1:0], 16'h0000);

    // 5. Async reset right after a read edge drops the result immediately.
    write(2'd0, 16'h0F0F);
    write(2'd3, 16'h7777);
    rd_en = 1'b1; rd_sel = 2'd3;
    tick();
    rd_en = 1'b0;
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    check("pre_rst_out", {16'h0, out}, 32'h7777);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_out", {16'h0, out}, 32'h0);
    check("async_rst_dirty", {28'h0, dirty}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    read_req(2'd3, 16'h0000);
    read_req(2'd0, 16'h0000);

    repeat (3) tick();
    check("sb_drain", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
